// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: L1 refill/write-back memory stage with fixed access latencies over a block store.
// Define CACHE_MEM_WBUF_EN to add a 1-entry posted write buffer with read bypass.
module cache_mem_ctrl #(
    parameter int PA_WIDTH  = 32,
    parameter int BLK_WIDTH = 512,
    parameter int OFF_BITS  = 6,
    parameter int MEM_DEPTH = 1024,
    parameter int RD_LAT    = 4,
    parameter int WR_LAT    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_rd_en,
    input  logic                 mem_wr_en,
    input  logic [PA_WIDTH-1:0]  mem_addr,
    input  logic [PA_WIDTH-1:0]  mem_wr_addr,
    input  logic [BLK_WIDTH-1:0] mem_wr_blk,
    output logic [BLK_WIDTH-1:0] mem_rd_blk,
    output logic                 mem_rd_valid,
    output logic                 mem_wr_done,
    output logic                 mem_busy
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2((RD_LAT > WR_LAT ? RD_LAT : WR_LAT) + 1);
    localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WR_LAT - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 rd_pend;
    logic [IDX_W-1:0]     rd_idx, wr_idx, a_idx, wa_idx;
    logic [BLK_WIDTH-1:0] wr_blk, rd_data;
    logic                 store_we;
    logic [BLK_WIDTH-1:0] store [MEM_DEPTH];
    logic                 unused_addr;

    // Upper address bits alias onto the same blocks by design
    assign a_idx       = mem_addr[OFF_BITS +: IDX_W];
    assign wa_idx      = mem_wr_addr[OFF_BITS +: IDX_W];
    assign unused_addr = ^{mem_addr[PA_WIDTH-1:OFF_BITS+IDX_W], mem_addr[OFF_BITS-1:0],
                           mem_wr_addr[PA_WIDTH-1:OFF_BITS+IDX_W], mem_wr_addr[OFF_BITS-1:0]};

`ifdef CACHE_MEM_WBUF_EN
    logic             wb_valid, wb_new;
    logic [CNT_W-1:0] wb_cnt;
    assign store_we = wb_valid && wb_cnt == '0 && !rst;
    assign rd_data  = (wb_valid && wr_idx == rd_idx) ? wr_blk : store[rd_idx];
    assign mem_busy = state != IDLE || (wb_valid && mem_wr_en);
`else
    assign store_we = state == WRITE && cnt == '0 && !rst;
    assign rd_data  = store[rd_idx];
    assign mem_busy = state != IDLE;
`endif

    always_ff @(posedge clk)
        if (store_we) store[wr_idx] <= wr_blk;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rd_pend      <= 1'b0;
            mem_rd_blk   <= '0;
            mem_rd_valid <= 1'b0;
            mem_wr_done  <= 1'b0;
`ifdef CACHE_MEM_WBUF_EN
            wb_valid     <= 1'b0;
            wb_new       <= 1'b0;
            wb_cnt       <= '0;
`endif
        end else begin
            mem_rd_valid <= 1'b0;
`ifdef CACHE_MEM_WBUF_EN
            mem_wr_done  <= wb_new;
            wb_new       <= 1'b0;
            if (wb_valid) begin
                wb_valid <= wb_cnt != '0;
                wb_cnt   <= wb_cnt - 1'b1;
            end
`else
            mem_wr_done  <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef CACHE_MEM_WBUF_EN
                    if (mem_wr_en && !wb_valid) begin
                        wr_idx   <= wa_idx;
                        wr_blk   <= mem_wr_blk;
                        wb_valid <= 1'b1;
                        wb_new   <= 1'b1;
                        wb_cnt   <= WR_INIT;
                    end
                    if (mem_rd_en && !(mem_wr_en && wb_valid)) begin
                        rd_idx <= a_idx;
                        cnt    <= RD_INIT;
                        state  <= READ;
                    end
`else
                    if (mem_wr_en) begin
                        wr_idx  <= wa_idx;
                        wr_blk  <= mem_wr_blk;
                        rd_idx  <= a_idx;
                        rd_pend <= mem_rd_en;
                        cnt     <= WR_INIT;
                        state   <= WRITE;
                    end else if (mem_rd_en) begin
                        rd_idx <= a_idx;
                        cnt    <= RD_INIT;
                        state  <= READ;
                    end
`endif
                end
                WRITE: begin
                    cnt <= cnt == '0 ? RD_INIT : cnt - 1'b1;
                    if (cnt == '0) begin
                        mem_wr_done <= 1'b1;
                        rd_pend     <= 1'b0;
                        state       <= rd_pend ? READ : IDLE;
                    end
                end
                READ: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        mem_rd_blk <= rd_data;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    mem_rd_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
